// File: rtl/fsk_pkg.sv
// Shared types and constants for the 2FSK frame sequencer.
package fsk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StData,
        StPar,
        StTail
    } fsk_state_t;

    localparam int unsigned FSK_BYTE_W    = 8;
    localparam logic        FSK_PRE_FIRST = 1'b1;

    function automatic logic fsk_even_parity(input logic [FSK_BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/fsk_frame_ctrl_if.sv
// Byte source handshake into the frame sequencer holding register.
interface fsk_frame_ctrl_if;

    logic [fsk_pkg::FSK_BYTE_W-1:0] data_in;
    logic                           data_last;
    logic                           data_valid;
    logic                           data_ready;

    modport master (
        output data_in,
        output data_last,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_in,
        input  data_last,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/fsk_sym_timer.sv
// Symbol period counter: strobe on the first cycle of each symbol, sym_end on the last.
module fsk_sym_timer #(
    parameter int unsigned SYM_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic stop,
    output logic sym_strobe,
    output logic sym_end
);

    localparam int unsigned CntW    = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SYM_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic            run_q;

    assign sym_end = run_q && (cnt_q == CntLast);

    // stop is only meaningful at the symbol boundary; it halts before the next symbol
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            run_q      <= 1'b0;
            sym_strobe <= 1'b0;
        end else if (start) begin
            cnt_q      <= '0;
            run_q      <= 1'b1;
            sym_strobe <= 1'b1;
        end else if (sym_end) begin
            cnt_q      <= '0;
            run_q      <= ~stop;
            sym_strobe <= ~stop;
        end else if (run_q) begin
            cnt_q      <= cnt_q + 1'b1;
            sym_strobe <= 1'b0;
        end else begin
            sym_strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/fsk_frame_ctrl.sv
// Frame sequencer for the 2FSK modulator: preamble, MSB-first bytes, idle tail symbol.
// Define FSK_PARITY_EN to append an even parity symbol after every byte.
module fsk_frame_ctrl
    import fsk_pkg::*;
#(
    parameter int unsigned SYM_DIV  = 16,
    parameter int unsigned PRE_LEN  = 8,
    parameter logic        IDLE_LVL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    fsk_frame_ctrl_if.slave        src,
    output logic                   m_ser_code_out,
    output logic                   sym_strobe,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned PreW = (PRE_LEN > 0) ? $clog2(PRE_LEN + 1) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(PRE_LEN);
    localparam bit PreEn = (PRE_LEN > 0);
    localparam logic [2:0] BitLast = 3'(FSK_BYTE_W - 1);

    fsk_state_t            state_q;
    logic [FSK_BYTE_W-1:0] shreg_q;
    logic [2:0]            bit_cnt_q;
    logic [PreW-1:0]       pre_cnt_q;
    logic                  last_q;
    logic                  ser_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
`ifdef FSK_PARITY_EN
    logic                  par_q;
`endif

    logic [FSK_BYTE_W-1:0] hold_data_q;
    logic                  hold_last_q;
    logic                  hold_full_q;

    logic sym_end;
    logic start_acc;
    logic byte_done;
    logic load_req;
    logic consume;
    logic underrun;
    logic frame_end;
    logic timer_start;

    always_comb begin
        start_acc = start && (state_q == StIdle);
`ifdef FSK_PARITY_EN
        byte_done = sym_end && (state_q == StPar);
`else
        byte_done = sym_end && (state_q == StData) && (bit_cnt_q == BitLast);
`endif
        // every point where a DATA symbol run is about to begin
        load_req    = (start_acc && !PreEn)
                   || (sym_end && (state_q == StPre) && (pre_cnt_q == PreLast))
                   || (byte_done && !last_q);
        underrun    = load_req && !hold_full_q;
        consume     = load_req && hold_full_q;
        frame_end   = (sym_end && (state_q == StTail)) || underrun;
        timer_start = start_acc && !underrun;
    end

    fsk_sym_timer #(
        .SYM_DIV (SYM_DIV)
    ) u_sym_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (timer_start),
        .stop       (frame_end),
        .sym_strobe (sym_strobe),
        .sym_end    (sym_end)
    );

    // Holding register: consumption wins, so a same-cycle offer waits for data_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
        end else if (consume) begin
            hold_full_q <= 1'b0;
        end else if (src.data_valid && !hold_full_q) begin
            hold_data_q <= src.data_in;
            hold_last_q <= src.data_last;
            hold_full_q <= 1'b1;
        end
    end

    assign src.data_ready = ~hold_full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            pre_cnt_q <= '0;
            last_q    <= 1'b0;
            ser_q     <= IDLE_LVL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef FSK_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (underrun) begin
                state_q <= StIdle;
                ser_q   <= IDLE_LVL;
                busy_q  <= 1'b0;
                err_q   <= 1'b1;
            end else if (consume) begin
                state_q   <= StData;
                shreg_q   <= hold_data_q;
                ser_q     <= hold_data_q[FSK_BYTE_W-1];
                bit_cnt_q <= '0;
                last_q    <= hold_last_q;
                busy_q    <= 1'b1;
`ifdef FSK_PARITY_EN
                par_q     <= fsk_even_parity(hold_data_q);
`endif
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start_acc) begin
                            state_q   <= StPre;
                            ser_q     <= FSK_PRE_FIRST;
                            pre_cnt_q <= PreW'(1);
                            busy_q    <= 1'b1;
                        end
                    end
                    StPre: begin
                        if (sym_end) begin
                            ser_q     <= ~ser_q;
                            pre_cnt_q <= pre_cnt_q + PreW'(1);
                        end
                    end
                    StData: begin
                        if (sym_end) begin
                            if (bit_cnt_q == BitLast) begin
`ifdef FSK_PARITY_EN
                                state_q <= StPar;
                                ser_q   <= par_q;
`else
                                state_q <= StTail;
                                ser_q   <= IDLE_LVL;
`endif
                            end else begin
                                shreg_q   <= {shreg_q[FSK_BYTE_W-2:0], 1'b0};
                                ser_q     <= shreg_q[FSK_BYTE_W-2];
                                bit_cnt_q <= bit_cnt_q + 3'd1;
                            end
                        end
                    end
`ifdef FSK_PARITY_EN
                    StPar: begin
                        if (sym_end) begin
                            state_q <= StTail;
                            ser_q   <= IDLE_LVL;
                        end
                    end
`endif
                    StTail: begin
                        if (sym_end) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign m_ser_code_out = ser_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_fsk_frame_ctrl.sv
// Self-checking bench for fsk_frame_ctrl: vector table, corner sequences, random frames.
module tb_fsk_frame_ctrl;

    localparam int unsigned SymDiv  = 4;
    localparam int unsigned PreLen  = 4;
    localparam logic        IdleLvl = 1'b1;
`ifdef FSK_PARITY_EN
    localparam bit ParEn = 1'b1;
`else
    localparam bit ParEn = 1'b0;
`endif
    // frame end cycles worked out by hand from the symbol counts
    localparam int EndA5   = ParEn ? 57 : 53;
    localparam int EndFf00 = ParEn ? 93 : 85;
    localparam int End3c   = ParEn ? 53 : 49;
    localparam int End3b   = ParEn ? 129 : 117;
    localparam int End2u   = ParEn ? 89 : 81;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ser, strobe, busy, done, err;

    fsk_frame_ctrl_if bus ();

    fsk_frame_ctrl #(
        .SYM_DIV  (SymDiv),
        .PRE_LEN  (PreLen),
        .IDLE_LVL (IdleLvl)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .src            (bus),
        .m_ser_code_out (ser),
        .sym_strobe     (strobe),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        bit          has_last;
        int          restart_at;
        int          exp_end;
        string       name;
    } vec_t;

    vec_t tbl[6];
    logic exp_sym[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the frame as a list of symbols; the outcome cycle follows from its length
    task automatic build_model(input logic [31:0] bytes, input int n, input bit has_last,
                               output int e);
        logic [7:0] b;
        exp_sym.delete();
        for (int i = 0; i < PreLen; i++) exp_sym.push_back(logic'(i % 2 == 0));
        for (int j = 0; j < n; j++) begin
            b = bytes[31-8*j -: 8];
            for (int k = 7; k >= 0; k--) exp_sym.push_back(b[k]);
            if (ParEn) exp_sym.push_back(^b);
        end
        if (has_last) exp_sym.push_back(IdleLvl);
        e = 1 + exp_sym.size() * SymDiv;
    endtask

    task automatic run_frame(input vec_t v);
        int e, exp_end, idx, gap, done_c, err_c, n_done, n_err;
        int bad_ser, bad_str, bad_busy;
        logic exp_ser, exp_str, exp_busy, x;
        build_model(v.bytes, v.n, v.has_last, e);
        exp_end = (v.exp_end != 0) ? v.exp_end : e;
        idx = 0; gap = 0; done_c = 0; err_c = 0; n_done = 0; n_err = 0;
        bad_ser = 0; bad_str = 0; bad_busy = 0;
        bus.data_valid = 1'b1;
        bus.data_in    = v.bytes[31:24];
        bus.data_last  = v.has_last && (v.n == 1);
        for (int t = 0; t < 4 && idx == 0; t++) begin
            x = bus.data_ready;
            step();
            if (x) idx = 1;
        end
        bus.data_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= e + 3; c++) begin
            exp_busy = (c < e);
            exp_ser  = (c < e) ? exp_sym[(c - 1) / SymDiv] : IdleLvl;
            exp_str  = (c < e) && ((c - 1) % SymDiv == 0);
            if (ser !== exp_ser) bad_ser++;
            if (strobe !== exp_str) bad_str++;
            if (busy !== exp_busy) bad_busy++;
            if (done === 1'b1) begin n_done++; if (done_c == 0) done_c = c; end
            if (err === 1'b1) begin n_err++; if (err_c == 0) err_c = c; end
            start = (c == v.restart_at);
            if (idx < v.n && gap == 0) begin
                bus.data_valid = 1'b1;
                bus.data_in    = v.bytes[31-8*idx -: 8];
                bus.data_last  = v.has_last && (idx == v.n - 1);
            end else begin
                bus.data_valid = 1'b0;
                if (gap > 0) gap--;
            end
            x = bus.data_valid && bus.data_ready;
            step();
            if (x) begin idx++; gap = $urandom_range(0, 2); end
        end
        start = 1'b0;
        bus.data_valid = 1'b0;
        check({v.name, "_ser_mismatch_cycles"}, bad_ser, 0);
        check({v.name, "_strobe_mismatch_cycles"}, bad_str, 0);
        check({v.name, "_busy_mismatch_cycles"}, bad_busy, 0);
        check({v.name, "_end_cycle"}, v.has_last ? done_c : err_c, exp_end);
        check({v.name, "_done_pulses"}, n_done, v.has_last ? 1 : 0);
        check({v.name, "_err_pulses"}, n_err, v.has_last ? 0 : 1);
    endtask

    initial begin
        int c, busy_cnt;
        vec_t rv;
        tbl[0] = '{32'hA500_0000, 1, 1'b1, 0, EndA5, "single_a5"};
        tbl[1] = '{32'hFF00_0000, 2, 1'b1, 0, EndFf00, "two_ff_00"};
        tbl[2] = '{32'h3C00_0000, 1, 1'b0, 0, End3c, "underrun_3c"};
        tbl[3] = '{32'hA500_0000, 1, 1'b1, 10, EndA5, "start_busy"};
        tbl[4] = '{32'h1234_5600, 3, 1'b1, 0, End3b, "three_bytes"};
        tbl[5] = '{32'hC35A_0000, 2, 1'b0, 0, End2u, "underrun_2nd"};
        bus.data_valid = 1'b0;
        bus.data_in    = '0;
        bus.data_last  = 1'b0;

        repeat (3) step();
        check("rst_ser", ser, IdleLvl);
        check("rst_ready", bus.data_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_strobe", strobe, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        step();

        // Preload holds data_ready low; an offer in the consume cycle is not taken
        bus.data_valid = 1'b1; bus.data_in = 8'hA5; bus.data_last = 1'b1;
        step();
        bus.data_valid = 1'b0;
        check("ready_after_preload", bus.data_ready, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 16; k++) step();
        check("ready_until_consume", bus.data_ready, 0);
        bus.data_valid = 1'b1; bus.data_in = 8'h77; bus.data_last = 1'b0;
        step();
        check("ready_rises_no_xfer", bus.data_ready, 1);
        bus.data_valid = 1'b0;
        c = 17;
        while (done !== 1'b1 && c < 80) begin step(); c++; end
        check("hand_done_cycle", c, EndA5);
        step();

        foreach (tbl[i]) run_frame(tbl[i]);

        // Reset in the middle of a frame with a second byte waiting
        bus.data_valid = 1'b1; bus.data_in = 8'hA5; bus.data_last = 1'b1;
        step();
        bus.data_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 18; k++) step();
        bus.data_valid = 1'b1; bus.data_in = 8'h5A; bus.data_last = 1'b1;
        step();
        bus.data_valid = 1'b0;
        check("hold_full_before_rst", bus.data_ready, 0);
        step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", bus.data_ready, 1);
        check("async_rst_ser", ser, IdleLvl);
        check("async_rst_strobe", strobe, 0);
        step();
        step();
        rst = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (busy === 1'b1 || strobe === 1'b1) busy_cnt++;
        end
        check("no_resume_after_rst", busy_cnt, 0);
        rv = tbl[0];
        rv.name = "after_rst";
        run_frame(rv);

        for (int r = 0; r < 8; r++) begin
            rv.bytes      = $urandom;
            rv.n          = $urandom_range(1, 4);
            rv.has_last   = ($urandom_range(0, 3) != 0);
            rv.restart_at = ($urandom_range(0, 1) != 0) ? $urandom_range(2, 40) : 0;
            rv.exp_end    = 0;
            rv.name       = $sformatf("rand%0d", r);
            run_frame(rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
